// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared definitions for the multiply/divide sequencer:
//               op encodings, op width, FSM states and default latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

  // Width of the op field carried from EX
  localparam int OP_W = 4;

  // Op encodings; 11-15 are reserved and behave as OP_NONE
  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd7;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd8;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd9;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd10;

  // Default busy latencies
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Sequencer states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Plain multiplies
  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Divides
  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Multiply-accumulate family
  function automatic logic op_is_madd(input logic [OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_core.sv
`default_nettype none
// ============================================================================
// Module      : md_div_core
// Description : Combinational 32-bit signed/unsigned divider. Quotient
//               truncates toward zero, remainder takes the dividend's sign.
//               Divide by zero returns zeros and raises div_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module md_div_core (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uquot;
  logic [31:0] urem;

  // Sign-magnitude divide: unsigned core on magnitudes, then restore signs.
  // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
  always_comb begin
    neg_a    = is_signed & dividend[31];
    neg_b    = is_signed & divisor[31];
    abs_a    = neg_a ? (32'd0 - dividend) : dividend;
    abs_b    = neg_b ? (32'd0 - divisor)  : divisor;
    div_zero = (divisor == 32'd0);
    if (div_zero) begin
      uquot = 32'd0;
      urem  = 32'd0;
    end else begin
      uquot = abs_a / abs_b;
      urem  = abs_a % abs_b;
    end
    quot = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
    rem  = neg_a ? (32'd0 - urem) : urem;
  end

endmodule
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer
// Description : HI/LO multiply/divide sequencer. Accepts an MD op from EX,
//               holds busy for a fixed latency, then writes HI/LO and pulses
//               done. MTHI/MTLO write directly with no busy period.
//               Optional: define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  input  logic            dis,
  output logic            busy,
  output logic            done,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [31:0]       rs_q,    rs_d;
  logic [31:0]       rt_q,    rt_d;
  logic [OP_W-1:0]   op_q,    op_d;
  logic [31:0]       hi_q,    hi_d;
  logic [31:0]       lo_q,    lo_d;
  logic              done_q,  done_d;

  logic              mul_class;
  logic signed [63:0] prod_s;
  logic [63:0]       prod_u;
  logic [31:0]       div_quot;
  logic [31:0]       div_rem;
  logic              div_zero;

  // Products from the latched operands only, so operand bus changes mid-op are harmless
  assign prod_s = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q});
  assign prod_u = {32'd0, rs_q} * {32'd0, rt_q};

  md_div_core u_div (
    .dividend  (rs_q),
    .divisor   (rt_q),
    .is_signed (op_q == OP_DIV),
    .quot      (div_quot),
    .rem       (div_rem),
    .div_zero  (div_zero)
  );

  // Ops that run with the multiply latency
  always_comb begin
`ifdef MD_MADD_EN
    mul_class = op_is_mul(op) || op_is_madd(op);
`else
    mul_class = op_is_mul(op);
`endif
  end

  // Next-state: accept in IDLE, count down in BUSY, commit HI/LO on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !dis) begin
          if (mul_class || op_is_div(op)) begin
            rs_d    = rs_val;
            rt_d    = rt_val;
            op_d    = op;
            cnt_d   = op_is_div(op) ? DIV_LD : MULT_LD;
            state_d = ST_BUSY;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV, OP_DIVU: begin
              // Divide by zero leaves HI/LO untouched but still completes
              if (!div_zero) begin
                hi_d = div_rem;
                lo_d = div_quot;
              end
            end
`ifdef MD_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      op_q    <= OP_NONE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sequencer
// Description : Self-checking bench for md_sequencer: cycle model of the
//               HI/LO unit plus directed vectors with literal expectations.
//               Handles builds with and without MD_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        dis;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .dis    (dis),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Remaining busy cycles plus the result that lands when they run out.
  int          m_left  = 0;
  bit          m_valid = 0;
  bit          m_done  = 0;
  logic [31:0] m_hi, m_lo;
  bit          p_wr;
  logic [63:0] p_res;
  logic [63:0] pp;
  int          sa, sb;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_done = 0; m_valid = 1;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          if (p_wr) {m_hi, m_lo} = p_res;
        end
      end else if (start && !dis) begin
        p_wr = 1;
        case (op)
          4'd1: begin m_left = MC; p_res = longint'($signed(rs_val)) * longint'($signed(rt_val)); end
          4'd2: begin m_left = MC; p_res = {32'd0, rs_val} * {32'd0, rt_val}; end
          4'd3, 4'd4: begin
            m_left = DC;
            if (rt_val == 0) p_wr = 0;
            else if (op == 4'd4) p_res = {rt_val == 0 ? 32'd0 : rs_val % rt_val, rs_val / rt_val};
            else begin
              sa = rs_val; sb = rt_val;
              if (sa == 32'sh80000000 && sb == -1) p_res = {32'd0, 32'h80000000};
              else p_res = {32'(sa % sb), 32'(sa / sb)};
            end
          end
          4'd5: m_hi = rs_val;
          4'd6: m_lo = rs_val;
`ifdef MD_MADD_EN
          4'd7, 4'd9: begin
            m_left = MC;
            pp = longint'($signed(rs_val)) * longint'($signed(rt_val));
            p_res = (op == 4'd7) ? ({m_hi, m_lo} + pp) : ({m_hi, m_lo} - pp);
          end
          4'd8, 4'd10: begin
            m_left = MC;
            pp = {32'd0, rs_val} * {32'd0, rt_val};
            p_res = (op == 4'd8) ? ({m_hi, m_lo} + pp) : ({m_hi, m_lo} - pp);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check32("model_busy", {31'd0, busy}, {31'd0, m_left > 0});
      check32("model_done", {31'd0, done}, {31'd0, m_done});
      check32("model_hi", hi, m_hi);
      check32("model_lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic d);
    @(negedge clk);
    start = 1; op = o; rs_val = a; rt_val = b; dis = d;
    @(negedge clk);
    start = 0; op = OP_NONE; dis = 0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bc, output int dc);
    int g;
    issue(o, a, b, 1'b0);
    bc = int'(busy); dc = int'(done);
    g = 0;
    while (busy === 1'b1 && g < 100) begin
      rs_val = $urandom; rt_val = $urandom;
      @(negedge clk);
      bc += int'(busy); dc += int'(done);
      g++;
    end
    if (g >= 100) begin
      total++; bad++;
      $display("FAIL timeout waiting for busy to drop: got busy=%b want 0", busy);
    end
    @(negedge clk);
    dc += int'(done);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy === 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      total++; bad++;
      $display("FAIL timeout waiting idle: got busy=%b want 0", busy);
    end
  endtask

  int bc, dc;

  initial begin
    reset = 1; start = 0; op = OP_NONE; rs_val = 0; rt_val = 0; dis = 0;
    repeat (2) @(negedge clk);
    check32("rst_hi", hi, 32'h0);
    check32("rst_lo", lo, 32'h0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    reset = 0;

    // MULT -2 * 3
    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, bc, dc);
    check32("mult_busy_cycles", bc, 5);
    check32("mult_done_pulses", dc, 1);
    check32("mult_hi", hi, 32'hFFFFFFFF);
    check32("mult_lo", lo, 32'hFFFFFFFA);

    // Signed MULT of two most-negative values
    run_op(OP_MULT, 32'h80000000, 32'h80000000, bc, dc);
    check32("multneg_hi", hi, 32'h40000000);
    check32("multneg_lo", lo, 32'h00000000);

    // Signed overflow divide
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    check32("divovf_lo", lo, 32'h80000000);
    check32("divovf_hi", hi, 32'h0);

    // DIV -7 / 2
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, bc, dc);
    check32("div_busy_cycles", bc, 10);
    check32("div_lo", lo, 32'hFFFFFFFD);
    check32("div_hi", hi, 32'hFFFFFFFF);

    // DIVU by zero
    run_op(OP_DIVU, 32'd7, 32'd0, bc, dc);
    check32("div0_busy_cycles", bc, 10);
    check32("div0_done_pulses", dc, 1);
    check32("div0_hi", hi, 32'hFFFFFFFF);
    check32("div0_lo", lo, 32'hFFFFFFFD);

    // MTHI killed, then real
    issue(OP_MTHI, 32'h12345678, 32'd0, 1'b1);
    check32("mthi_dis_hi", hi, 32'hFFFFFFFF);
    issue(OP_MTHI, 32'h12345678, 32'd0, 1'b0);
    check32("mthi_hi", hi, 32'h12345678);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OP_MTLO, 32'hCAFEF00D, 32'd0, 1'b0);
    check32("mtlo_lo", lo, 32'hCAFEF00D);

    // Reserved and NONE ops: no effect
    issue(4'd12, 32'h1, 32'h1, 1'b0);
    issue(OP_NONE, 32'h1, 32'h1, 1'b0);
    check32("rsvd_hi", hi, 32'h12345678);
    check32("rsvd_lo", lo, 32'hCAFEF00D);
    check32("rsvd_busy", {31'd0, busy}, 32'd0);

    // MULTU with mid-busy start and dis, then DIVU back-to-back in the done cycle
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(negedge clk); start = 1; op = OP_DIV; rs_val = 1; rt_val = 1;
    @(negedge clk); start = 0; op = OP_NONE; dis = 1;
    @(negedge clk); dis = 0;
    wait_idle();
    check32("b2b_done", {31'd0, done}, 32'd1);
    check32("multu_hi", hi, 32'hFFFFFFFE);
    check32("multu_lo", lo, 32'h00000001);
    start = 1; op = OP_DIVU; rs_val = 10; rt_val = 3;
    @(negedge clk); start = 0; op = OP_NONE;
    check32("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check32("divu_hi", hi, 32'd1);
    check32("divu_lo", lo, 32'd3);

    // Reset in the 4th busy cycle of a DIV
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check32("rstmid_busy", {31'd0, busy}, 32'd0);
    check32("rstmid_hi", hi, 32'd0);
    check32("rstmid_lo", lo, 32'd0);
    reset = 0;
    @(negedge clk);
    check32("rstmid_done", {31'd0, done}, 32'd0);

    // MADDU accumulate (or no-op without the feature)
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op(OP_MADDU, 32'd1, 32'd1, bc, dc);
`ifdef MD_MADD_EN
    check32("maddu_busy_cycles", bc, 5);
    check32("maddu_hi", hi, 32'd1);
    check32("maddu_lo", lo, 32'd0);
    run_op(OP_MSUB, 32'd2, 32'hFFFFFFFF, bc, dc);
    check32("msub_hi", hi, 32'd1);
    check32("msub_lo", lo, 32'd2);
`else
    check32("maddu_off_busy", bc, 0);
    check32("maddu_off_hi", hi, 32'd0);
    check32("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
